// File: rtl/sm83_pkg.sv
// Shared SM83 bus definitions: wrz transfer encodings and the membus_port state encoding.
package sm83_pkg;

    localparam logic [1:0] WRZ_WRITE = 2'd0;
    localparam logic [1:0] WRZ_READ  = 2'd1;
    localparam logic [1:0] WRZ_HIZ   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_CAPTURE,
        ST_WAIT,
        ST_DONE,
        ST_HOLD
    } membus_state_t;

    // Codes 2 and 3 both mean "bus released".
    function automatic logic wrz_is_release(input logic [1:0] wrz);
        return wrz[1];
    endfunction

endpackage

// File: rtl/membus_wait_ctr.sv
// 4-bit loadable down-counter that paces the wait-state phase of a bus access.
module membus_wait_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_val,
    output logic [3:0] value,
    output logic       zero
);

    always_ff @(posedge clk) begin
        if (rst)
            value <= 4'd0;
        else if (load)
            value <= load_val;
        else if (dec && value != 4'd0)
            value <= value - 4'd1;
    end

    assign zero = (value == 4'd0);

endmodule

// File: rtl/membus_port.sv
// Responder for the wrz bus-transfer protocol, fronting a 1-cycle-latency single-port RAM.
module membus_port
    import sm83_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_bus,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        mem_wrz,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic              ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    membus_state_t state;
    logic          is_read;
    logic          accept;
    logic [3:0]    wait_val;
    logic          wait_zero;
    logic          wait_last;

    assign accept    = (state == ST_IDLE) && !wrz_is_release(mem_wrz);
    assign wait_last = (wait_val == 4'd1);

    // Loaded at accept so the zero flag already says whether WAIT is skipped.
    membus_wait_ctr u_wait_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .dec      (state == ST_WAIT),
        .load_val (4'(WAIT_STATES)),
        .value    (wait_val),
        .zero     (wait_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            is_read   <= 1'b0;
            data_out  <= '0;
            data_oe   <= 1'b0;
            ready     <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            ready  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ram_en   <= 1'b1;
                        ram_we   <= (mem_wrz == WRZ_WRITE);
                        ram_addr <= addr_bus;
                        is_read  <= (mem_wrz == WRZ_READ);
                        if (mem_wrz == WRZ_WRITE)
                            ram_wdata <= data_in;
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (is_read)
                        state <= ST_CAPTURE;
                    else if (wait_zero) begin
                        ready <= 1'b1;
                        state <= ST_DONE;
                    end else
                        state <= ST_WAIT;
                end
                ST_CAPTURE: begin
                    data_out <= ram_rdata;
                    data_oe  <= 1'b1;
                    if (wait_zero) begin
                        ready <= 1'b1;
                        state <= ST_DONE;
                    end else
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_last) begin
                        ready <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_HOLD;
                ST_HOLD: begin
                    // A held write here is the requester skipping release; never execute it.
                    if (mem_wrz != WRZ_READ)
                        data_oe <= 1'b0;
                    if (wrz_is_release(mem_wrz))
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/membus_port.md
# membus_port

Responder end of the CPU's 2-bit `wrz` bus-transfer protocol, the same encoding the register file uses: 0 = write from data bus, 1 = drive onto data bus, 2 = release.

- The requester places an address on `addr_bus`, holds a `wrz` command on `mem_wrz` and waits for `ready`.
- `membus_port` performs the access on a synchronous single-port RAM (1-cycle read latency) with configurable wait states, then signals completion.
- Sits between the register file's address/data buses and block RAM. The top level owns the actual tri-state using `data_oe`.

## Interface
- `ADDR_W`, 16, address bus width.
- `DATA_W`, 8, data bus width.
- `WAIT_STATES`, 1, extra idle cycles inserted before `ready`. Legal range 0..15.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `addr_bus` in ADDR_W: access address, sampled when a command is accepted.
- `data_in` in DATA_W: write data from the data bus, sampled when a write is accepted.
- `mem_wrz` in 2: command. 0 = write, 1 = read (drive bus), 2 = release/idle, 3 = treated as 2.
- `data_out` out DATA_W: registered read data.
- `data_oe` out 1: top level drives `data_out` onto the data bus while high.
- `ready` out 1: one-cycle completion pulse.
- `ram_en` out 1: RAM enable (registered).
- `ram_we` out 1: RAM write enable (registered).
- `ram_addr` out ADDR_W: RAM address (registered).
- `ram_wdata` out DATA_W: RAM write data (registered).
- `ram_rdata` in DATA_W: RAM read data, valid the cycle after `ram_en` && !`ram_we`.

## Operation

States: IDLE, ACCESS, CAPTURE, WAIT, DONE, HOLD.

- **IDLE**
  - `mem_wrz`==0 or 1 is sampled: latch `addr_bus` (and `data_in` for a write) into `ram_addr`/`ram_wdata`. Go to ACCESS.
  - Any other value: stay.
- **ACCESS**
  - `ram_en`=1 for exactly one cycle.
  - `ram_we`=1 only for a write.
  - Next state: write → WAIT; read → CAPTURE.
- **CAPTURE** (read only): `data_out`<=`ram_rdata`, `data_oe`<=1. Go to WAIT.
- **WAIT**: counter loaded with `WAIT_STATES` on entry. Decrement each cycle; go to DONE when it is 0. With `WAIT_STATES`=0, WAIT lasts zero cycles (pass straight to DONE).
- **DONE**: `ready`=1 for one cycle. Go to HOLD.
- **HOLD**
  - Waits for the requester to release: `mem_wrz` sampled as 2 or 3 → IDLE.
  - `data_oe` stays 1 while `mem_wrz` is sampled ==1. It clears on the edge that samples any other value.
  - `mem_wrz`==0 sampled in HOLD (read→write without release): `data_oe` cleared, stay in HOLD, no write occurs.

Command handling rules:
- `mem_wrz`, `addr_bus` and `data_in` changes between accept and `ready` are ignored.
- The requester must hold the command until `ready`, then release for ≥1 cycle.
- A command held past `ready` is never re-executed.

## Timing
- Let edge k be the edge that accepts a command in IDLE.
- Write:
  - `ram_en`/`ram_we` high in cycle k+1.
  - `ready` high in cycle k+2+WAIT_STATES.
- Read:
  - `ram_en` high in cycle k+1.
  - `data_out` valid and `data_oe`=1 from cycle k+3.
  - `ready` high in cycle k+3+WAIT_STATES.
- With default `WAIT_STATES`=1: write completes in 4 cycles (one SM83 M-cycle), read in 5.
- Earliest next accept: the edge after the release is sampled in HOLD.
- Reset values: `data_out`=0, `data_oe`=0, `ready`=0, `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0. State = IDLE, wait counter = 0.
- Reset mid-operation: all outputs return to reset values at the next edge; no `ready` is issued.
  - A write whose ACCESS cycle already occurred stays committed.
  - A write that has not yet reached ACCESS is never issued.
- `rst` has priority over every command.

## Structure
- Shared package `sm83_pkg` holds:
  - `wrz` encodings: `WRZ_WRITE`=2'd0, `WRZ_READ`=2'd1, `WRZ_HIZ`=2'd2. These are shared with the register file and testbenches.
  - The state encoding for this block.
- One sub-module: `membus_wait_ctr`, a 4-bit loadable down-counter with `load`, `value` and `zero` outputs.
- RAM is external to this block.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `mem_wrz`=0 → no `ram_en`; all outputs 0; state IDLE.
- **Write:** `addr_bus`=16'hC000, `data_in`=8'h3F, `mem_wrz`=0 held → `ram_we`=1 with `ram_addr`=C000, `ram_wdata`=3F in cycle k+1; `ready` in cycle k+3; no second write while the command is still held.
- **Read-back:** `mem_wrz`=2 for 1 cycle, then `mem_wrz`=1 at C000 (RAM model returns 3F) → `data_out`=3F, `data_oe`=1 from cycle k+3; `ready` at k+4; `data_oe` drops the cycle after `mem_wrz`=2.
- **Zero wait / back-to-back:** `WAIT_STATES`=0, alternate write A=0x0010/D=0xA5 with release cycles and reads of 0x0010 → `ready` latency 2 (write) and 3 (read); read returns A5.
- **Illegal command:** `mem_wrz`=3 in IDLE for 5 cycles → no RAM activity. `mem_wrz`=0 directly after a read in HOLD → `data_oe` clears, no `ram_we`.
- **Reset mid-access:** assert `rst` in the CAPTURE cycle of a read → no `ready`; `data_oe`=0; IDLE next cycle; the next command is accepted normally.
